// File: rtl/sram_ctrl_pkg.sv
// Shared pipeline definitions for the 16-bit external SRAM memory stage.
// Holds the controller state encoding and the SRAM bus geometry.
package sram_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;
   localparam int          SRAM_ADDR_W       = 18;
   localparam int          SRAM_DATA_W       = 16;

endpackage

// File: rtl/sram_ctrl.sv
// Memory-stage controller: splits each 32-bit load/store into two 16-bit SRAM
// phases (low half, then high half) and stalls the pipeline until done.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   rd_en,
   input  logic                   wr_en,
   input  logic [31:0]            address,
   input  logic [31:0]            write_data,
   output logic [31:0]            read_data,
   output logic                   ready,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic [SRAM_DATA_W-1:0] sram_dq_out,
   output logic                   sram_dq_oe,
   input  logic [SRAM_DATA_W-1:0] sram_dq_in,
   output logic                   sram_we_n
);

   localparam logic [2:0] LAST_WAIT = 3'(WAIT_CYCLES);

   state_t                 state;
   logic [2:0]             wait_cnt;
   logic [SRAM_ADDR_W-2:0] word_idx;
   logic [31:0]            wdata;
   logic                   op_write;

   logic                   request;
   logic                   phase_end;
   logic [SRAM_ADDR_W-2:0] req_idx;

   assign request   = rd_en | wr_en;
   assign phase_end = (wait_cnt == LAST_WAIT);
   // Word index wraps modulo 2^17; addresses below BASE_ADDR alias high words.
   assign req_idx   = 17'((address - BASE_ADDR) >> 2);

   assign ready = (state == DONE) || ((state == IDLE) && !request);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         wait_cnt    <= 3'd0;
         word_idx    <= '0;
         wdata       <= 32'd0;
         op_write    <= 1'b0;
         read_data   <= 32'd0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (request) begin
                  state       <= LOW;
                  wait_cnt    <= 3'd0;
                  word_idx    <= req_idx;
                  wdata       <= write_data;
                  op_write    <= wr_en;
                  sram_addr   <= {req_idx, 1'b0};
                  sram_dq_out <= write_data[15:0];
                  sram_dq_oe  <= wr_en;
                  sram_we_n   <= ~wr_en;
               end
            end
            LOW: begin
               if (phase_end) begin
                  state       <= HIGH;
                  wait_cnt    <= 3'd0;
                  sram_addr   <= {word_idx, 1'b1};
                  sram_dq_out <= wdata[31:16];
                  if (!op_write) begin
                     read_data[15:0] <= sram_dq_in;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 3'd1;
               end
            end
            HIGH: begin
               if (phase_end) begin
                  state      <= DONE;
                  wait_cnt   <= 3'd0;
                  sram_dq_oe <= 1'b0;
                  sram_we_n  <= 1'b1;
                  if (!op_write) begin
                     read_data[31:16] <= sram_dq_in;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 3'd1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench: two controllers (WAIT_CYCLES=1 and 0), each with a simple
// behavioural SRAM, driven through writes, reads, combined requests and reset.
module tb_sram_ctrl;

   logic        clk;
   logic        rst_n;

   logic        rd_en_a, wr_en_a, ready_a, sram_dq_oe_a, sram_we_n_a;
   logic [31:0] address_a, write_data_a, read_data_a;
   logic [17:0] sram_addr_a;
   logic [15:0] sram_dq_out_a, sram_dq_in_a;

   logic        rd_en_b, wr_en_b, ready_b, sram_dq_oe_b, sram_we_n_b;
   logic [31:0] address_b, write_data_b, read_data_b;
   logic [17:0] sram_addr_b;
   logic [15:0] sram_dq_out_b, sram_dq_in_b;

   logic [15:0] mem_a [0:262143] = '{default: 16'h0000};
   logic [15:0] mem_b [0:262143] = '{default: 16'h0000};

   int errors = 0;
   int checks = 0;

   logic        o_ready, o_oe, o_we_n;
   logic [17:0] o_addr;
   logic [15:0] o_dq;
   logic [31:0] o_rdata;

   sram_ctrl #(.WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) dut_a (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en_a), .wr_en(wr_en_a),
      .address(address_a), .write_data(write_data_a), .read_data(read_data_a),
      .ready(ready_a), .sram_addr(sram_addr_a), .sram_dq_out(sram_dq_out_a),
      .sram_dq_oe(sram_dq_oe_a), .sram_dq_in(sram_dq_in_a), .sram_we_n(sram_we_n_a)
   );

   sram_ctrl #(.WAIT_CYCLES(0), .BASE_ADDR(32'd1024)) dut_b (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en_b), .wr_en(wr_en_b),
      .address(address_b), .write_data(write_data_b), .read_data(read_data_b),
      .ready(ready_b), .sram_addr(sram_addr_b), .sram_dq_out(sram_dq_out_b),
      .sram_dq_oe(sram_dq_oe_b), .sram_dq_in(sram_dq_in_b), .sram_we_n(sram_we_n_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Asynchronous-read SRAM, write strobe sampled on the rising edge.
   assign sram_dq_in_a = mem_a[sram_addr_a];
   assign sram_dq_in_b = mem_b[sram_addr_b];
   always @(posedge clk) begin
      if (!sram_we_n_a) mem_a[sram_addr_a] <= sram_dq_out_a;
      if (!sram_we_n_b) mem_b[sram_addr_b] <= sram_dq_out_b;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic sample(input bit b);
      o_ready = b ? ready_b       : ready_a;
      o_addr  = b ? sram_addr_b   : sram_addr_a;
      o_dq    = b ? sram_dq_out_b : sram_dq_out_a;
      o_oe    = b ? sram_dq_oe_b  : sram_dq_oe_a;
      o_we_n  = b ? sram_we_n_b   : sram_we_n_a;
      o_rdata = b ? read_data_b   : read_data_a;
   endtask

   // Starts from an IDLE cycle, returns 1 time unit into the DONE cycle.
   task automatic access(input bit b, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [16:0] idx, input logic [31:0] exp_rdata);
      int len;
      int busy;
      int we_low;
      int ph;
      bit done;
      len    = b ? 1 : 2;
      busy   = 0;
      we_low = 0;
      done   = 1'b0;
      if (b) begin
         rd_en_b = rd; wr_en_b = wr; address_b = a; write_data_b = d;
      end else begin
         rd_en_a = rd; wr_en_a = wr; address_a = a; write_data_a = d;
      end
      #1;
      sample(b);
      chk("req_ready", 32'(o_ready), 32'd0);
      busy = 1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         sample(b);
         if (o_ready) begin
            done = 1'b1;
            break;
         end
         busy++;
         ph = (k - 1) / len;
         chk("phase_addr", 32'(o_addr), 32'({idx, ph[0]}));
         if (wr) begin
            chk("wr_we_n", 32'(o_we_n), 32'd0);
            chk("wr_oe", 32'(o_oe), 32'd1);
            chk("wr_dq", 32'(o_dq), ph[0] ? 32'(d[31:16]) : 32'(d[15:0]));
         end else begin
            chk("rd_we_n", 32'(o_we_n), 32'd1);
            chk("rd_oe", 32'(o_oe), 32'd0);
         end
         if (!o_we_n) we_low++;
      end
      chk("done_reached", 32'(done), 32'd1);
      chk("latency", 32'(busy), 32'(2 * len + 1));
      chk("we_low_cycles", 32'(we_low), wr ? 32'(2 * len) : 32'd0);
      chk("done_we_n", 32'(o_we_n), 32'd1);
      chk("done_oe", 32'(o_oe), 32'd0);
      chk("done_addr_held", 32'(o_addr), 32'({idx, 1'b1}));
      chk("read_data", o_rdata, exp_rdata);
   endtask

   initial begin
      rst_n = 1'b0;
      rd_en_a = 0; wr_en_a = 0; address_a = 0; write_data_a = 0;
      rd_en_b = 0; wr_en_b = 0; address_b = 0; write_data_b = 0;
      #12;
      sample(0);
      chk("rst_ready", 32'(o_ready), 32'd1);
      chk("rst_we_n", 32'(o_we_n), 32'd1);
      chk("rst_oe", 32'(o_oe), 32'd0);
      chk("rst_addr", 32'(o_addr), 32'd0);
      chk("rst_dq", 32'(o_dq), 32'd0);
      chk("rst_rdata", o_rdata, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Write 0xDEADBEEF to 1024, then read it back.
      access(0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 17'd0, 32'd0);
      wr_en_a = 0;
      $display("write a=1024 d=deadbeef done");
      @(posedge clk); #1;
      access(0, 1'b1, 1'b0, 32'd1024, 32'd0, 17'd0, 32'hDEADBEEF);
      rd_en_a = 0;
      $display("read a=1024 rdata=%08h", read_data_a);
      @(posedge clk); #1;

      // Combined rd/wr request behaves as a write; read_data untouched.
      access(0, 1'b1, 1'b1, 32'd1028, 32'h12345678, 17'd1, 32'hDEADBEEF);
      rd_en_a = 0; wr_en_a = 0;
      $display("rd+wr a=1028 d=12345678 done");
      @(posedge clk); #1;
      chk("idle_ready", 32'(ready_a), 32'd1);

      // Reset during the HIGH phase of a write.
      wr_en_a = 1; address_a = 32'd1036; write_data_a = 32'hCAFEF00D;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_rst_addr", 32'(sram_addr_a), 32'd7);
      chk("pre_rst_we_n", 32'(sram_we_n_a), 32'd0);
      rst_n = 1'b0; wr_en_a = 0;
      #1;
      sample(0);
      chk("mid_rst_we_n", 32'(o_we_n), 32'd1);
      chk("mid_rst_oe", 32'(o_oe), 32'd0);
      chk("mid_rst_ready", 32'(o_ready), 32'd1);
      chk("mid_rst_addr", 32'(o_addr), 32'd0);
      chk("mid_rst_rdata", o_rdata, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_ready", 32'(ready_a), 32'd1);
      chk("post_rst_we_n", 32'(sram_we_n_a), 32'd1);
      access(0, 1'b1, 1'b0, 32'd1036, 32'd0, 17'd3, 32'h0000F00D);
      rd_en_a = 0;
      $display("reset-aborted write, read a=1036 rdata=%08h", read_data_a);
      @(posedge clk); #1;

      // Back-to-back reads with the request held through DONE.
      access(0, 1'b1, 1'b0, 32'd1024, 32'd0, 17'd0, 32'hDEADBEEF);
      address_a = 32'd1028;
      #1;
      chk("b2b_done_ready", 32'(ready_a), 32'd1);
      @(posedge clk); #1;
      access(0, 1'b1, 1'b0, 32'd1028, 32'd0, 17'd1, 32'h12345678);
      rd_en_a = 0;
      $display("back-to-back read a=1028 rdata=%08h", read_data_a);
      @(posedge clk); #1;
      chk("b2b_idle_ready", 32'(ready_a), 32'd1);
      @(posedge clk); #1;
      chk("b2b_no_dup_ready", 32'(ready_a), 32'd1);
      chk("b2b_no_dup_addr", 32'(sram_addr_a), 32'd3);

      // WAIT_CYCLES=0 instance.
      access(1, 1'b0, 1'b1, 32'd1032, 32'hA5A55A5A, 17'd2, 32'd0);
      wr_en_b = 0;
      $display("w0 write a=1032 d=a5a55a5a done");
      @(posedge clk); #1;
      access(1, 1'b1, 1'b0, 32'd1032, 32'd0, 17'd2, 32'hA5A55A5A);
      rd_en_b = 0;
      $display("w0 read a=1032 rdata=%08h", read_data_b);
      @(posedge clk); #1;
      chk("w0_idle_ready", 32'(ready_b), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 1: extra hold cycles per SRAM half-word phase; range 0..7.
REQ-002 Parameter BASE_ADDR, default 32'd1024: byte address that maps to SRAM word 0.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 rd_en  in  1  memory read request, from EX/MEM register mem_read_en_out.
REQ-006 wr_en  in  1  memory write request, from EX/MEM register mem_write_en_out.
REQ-007 address  in  32  byte address, from EX/MEM alu_res_out.
REQ-008 write_data  in  32  store data, from EX/MEM val_rm_out.
REQ-009 read_data  out  32  last completed load word, feeds MEM/WB register.
REQ-010 ready  out  1  high = pipeline may advance; low = freeze all pipeline registers and PC.
REQ-011 sram_addr  out  18  half-word address to external SRAM.
REQ-012 sram_dq_out  out  16  write data to SRAM data bus.
REQ-013 sram_dq_oe  out  1  tristate enable for sram_dq_out.
REQ-014 sram_dq_in  in  16  read data from SRAM data bus.
REQ-015 sram_we_n  out  1  SRAM write strobe, active-low.

Function
REQ-016 States: IDLE, LOW, HIGH, DONE.
REQ-017 Request = rd_en | wr_en; wr_en and rd_en both high -> write performed, read_data unchanged.
REQ-018 IDLE + request -> latch address, write_data, op (write/read); next state LOW, wait counter cleared.
REQ-019 IDLE + no request -> stay IDLE.
REQ-020 Word index = (address - BASE_ADDR)[18:2], 32-bit subtract, no range check, wraps modulo 2^17.
REQ-021 sram_addr = {word index, 1'b0} in LOW, {word index, 1'b1} in HIGH, held unchanged in IDLE/DONE.
REQ-022 LOW and HIGH each last exactly WAIT_CYCLES+1 cycles, counted by a 3-bit wait counter; LOW -> HIGH -> DONE.
REQ-023 Write: sram_we_n low and sram_dq_oe high during all LOW/HIGH cycles; sram_dq_out = write_data[15:0] in LOW, [31:16] in HIGH.
REQ-024 Read: sram_we_n high, sram_dq_oe low; sram_dq_in sampled on the last cycle of LOW into read_data[15:0], last cycle of HIGH into read_data[31:16].
REQ-025 DONE -> IDLE unconditionally, one cycle.
REQ-026 ready combinational: 1 in DONE, 1 in IDLE with no request, 0 otherwise.
REQ-027 Latency: ready low for 2*(WAIT_CYCLES+1)+1 consecutive cycles per access, high for the DONE cycle.
REQ-028 read_data holds its value between completed reads; unchanged by writes.
REQ-029 Inputs sampled only in IDLE; changes during LOW/HIGH/DONE ignored.

Reset
REQ-030 rst_n low -> immediately: state IDLE, counter 0, read_data 0, sram_addr 0, sram_dq_out 0, sram_dq_oe 0, sram_we_n 1.
REQ-031 Reset mid-access aborts; partial write may persist in SRAM; no retry after release.
REQ-032 First rising edge after rst_n high behaves as IDLE.

Structure
REQ-033 Shared pipeline package holds: state enum, BASE_ADDR default, SRAM_ADDR_W=18, SRAM_DATA_W=16.
REQ-034 Single flat module; no sub-module (wait counter is inline).

Verification
REQ-035 WAIT_CYCLES=1, write 0xDEADBEEF to 1024 -> ready low 5 cycles; sram_addr 0 with dq 0xBEEF two cycles, then 1 with 0xDEAD two cycles; we_n low 4 cycles.
REQ-036 Read 1024 after REQ-035, SRAM model returns stored halves -> read_data = 0xDEADBEEF on DONE cycle, ready high that cycle.
REQ-037 WAIT_CYCLES=0, write address 1032 -> sram_addr 4 then 5, ready low exactly 3 cycles.
REQ-038 rd_en=wr_en=1, address 1028, data 0x12345678 -> write at sram_addr 2/3, read_data unchanged.
REQ-039 rst_n pulsed low during HIGH of a write -> we_n=1, oe=0, ready=1 same cycle; next request starts clean from LOW.
REQ-040 Back-to-back reads 1024, 1028 held by frozen pipeline -> two full accesses, one DONE cycle between, no access lost or duplicated.
